// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
// Shared definitions for the memory-access unit: access-size encodings,
// controller state encoding, legal read-latency range and the alignment rule.
// No ports (package).
package mem_access_unit_pkg;

  // Access size encodings as delivered by the control unit.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;  // reserved, behaves as a word access

  // Legal memory read latency (cycles from address-valid to data-valid).
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  // Wait counter holds MEM_LAT-1, so two bits cover the legal range.
  localparam int CNT_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RMW_WR,
    ST_DONE
  } state_t;

  function automatic logic is_word(input logic [1:0] size);
    return (size == SZ_WORD) || (size == SZ_RSVD);
  endfunction

  // Halfwords need an even address, words (and the reserved size) need a
  // multiple of four; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_HALF: mis = off[0];
      SZ_BYTE: mis = 1'b0;
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Bundles the request side (control unit), the memory side and the result
// side of the memory-access unit.
//   slave  : used by mem_access_unit (takes requests and read data, drives
//            memory address/write and the load result/status)
//   master : used by whatever plays control unit plus data memory
interface mem_access_unit_if;
  // request from the control unit
  logic        start;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wr_data;
  // data memory port
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  // result / status
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        misaligned;

  modport slave (
    input  start, we, size, sign_ext, addr, wr_data, mem_rdata,
    output mem_addr, mem_wr, mem_wdata, rd_data, busy, done, misaligned
  );

  modport master (
    output start, we, size, sign_ext, addr, wr_data, mem_rdata,
    input  mem_addr, mem_wr, mem_wdata, rd_data, busy, done, misaligned
  );
endinterface

// File: rtl/mem_access_unit_lane_unit.sv
// lane_unit
// Purely combinational little-endian lane logic shared by the load path and
// the read-modify-write store path.
//   word      : 32-bit memory word being operated on
//   size      : access size (word / half / byte; reserved acts as word)
//   offset    : byte offset within the word (addr[1:0])
//   sign_ext  : 1 = sign-extend the extracted lane, 0 = zero-extend
//   wr_data   : right-justified store data
//   load_data : extracted and extended load value
//   merged    : word with the store lane replaced (wr_data for word stores)
module lane_unit
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wr_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? word[31:16] : word[15:0];
    load_data = word;
    merged    = wr_data;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
        merged    = word;
        merged[{offset, 3'b000} +: 8] = wr_data[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
        merged    = word;
        merged[{offset[1], 4'b0000} +: 16] = wr_data[15:0];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Sequential memory-access controller sitting after the IorD address mux.
// Performs word/half/byte loads with sign or zero extension, word stores
// directly and sub-word stores by read-modify-write; misaligned requests are
// answered with a done+misaligned pulse without touching memory.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mem_access_unit_if.slave (request, memory port, result/status)
// MEM_LAT is the memory read latency, legal range 1..4.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              mis_q, mis_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [31:0]       mem_addr_q, mem_addr_d;

  logic [31:0]       lane_word;
  logic [31:0]       lane_load;
  logic [31:0]       lane_merged;

  // In WAIT the lane logic looks at the live read data so the load result can
  // be registered on the sampling edge; in RMW_WR it works on the captured word.
  assign lane_word = (state_q == ST_WAIT) ? bus.mem_rdata : data_q;

  lane_unit u_lane (
    .word      (lane_word),
    .size      (size_q),
    .offset    (off_q),
    .sign_ext  (sext_q),
    .wr_data   (wr_data_q),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      size_q     <= SZ_WORD;
      sext_q     <= 1'b0;
      off_q      <= 2'b00;
      wr_data_q  <= '0;
      mis_q      <= 1'b0;
      data_q     <= '0;
      rd_data_q  <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      off_q      <= off_d;
      wr_data_q  <= wr_data_d;
      mis_q      <= mis_d;
      data_q     <= data_d;
      rd_data_q  <= rd_data_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    off_d      = off_q;
    wr_data_d  = wr_data_q;
    mis_d      = mis_q;
    data_d     = data_q;
    rd_data_d  = rd_data_q;
    mem_addr_d = mem_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          we_d      = bus.we;
          size_d    = bus.size;
          sext_d    = bus.sign_ext;
          off_d     = bus.addr[1:0];
          wr_data_d = bus.wr_data;
          mis_d     = is_misaligned(bus.size, bus.addr[1:0]);
          if (mis_d) begin
            // mem_addr keeps its previous value: memory is not addressed.
            state_d = ST_DONE;
          end else begin
            // Registering the address here makes it valid from the first
            // cycle of REQ / RMW_WR and keeps it stable through DONE.
            mem_addr_d = {bus.addr[31:2], 2'b00};
            state_d    = (bus.we && is_word(bus.size)) ? ST_RMW_WR : ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d   = CNT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          data_d = bus.mem_rdata;
          if (we_q) begin
            state_d = ST_RMW_WR;
          end else begin
            rd_data_d = lane_load;
            state_d   = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RMW_WR: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wr     = (state_q == ST_RMW_WR);
  // Gated so the write bus is quiet except during the write cycle.
  assign bus.mem_wdata  = bus.mem_wr ? lane_merged : '0;
  assign bus.rd_data    = rd_data_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.misaligned = (state_q == ST_DONE) && mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// Testbench for mem_access_unit. Two instances run in lockstep on identical
// requests, one with MEM_LAT=1 and one with MEM_LAT=3, each with its own
// synchronous memory model. Results are compared with a behavioural model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wr_data = '0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  int tests = 0;
  int fails = 0;

  // behavioural model state
  logic [31:0] ref_mem [0:255];
  logic [31:0] ref_rd = '0;
  logic [31:0] ref_maddr = '0;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    mem_access_unit_if mif ();
    logic [31:0] mem  [0:255];
    logic [31:0] pipe [0:LAT-1];
    int n_done = 0, n_wr = 0, n_busy = 0, done_cyc = 0, wr_cyc = 0;
    logic        mis_s = 1'b0;
    logic [31:0] maddr_s = '0, wdata_s = '0, waddr_s = '0;
    logic [99:0] outs_vec;

    assign mif.start     = start;
    assign mif.we        = we;
    assign mif.size      = size;
    assign mif.sign_ext  = sign_ext;
    assign mif.addr      = addr;
    assign mif.wr_data   = wr_data;
    assign mif.mem_rdata = pipe[LAT-1];
    assign outs_vec = {mif.mem_addr, mif.mem_wr, mif.mem_wdata, mif.rd_data,
                       mif.busy, mif.done, mif.misaligned};

    mem_access_unit #(.MEM_LAT(LAT)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mif)
    );

    // synchronous single-port memory with LAT cycles of read latency
    always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_val;
      else if (mif.mem_wr) mem[mif.mem_addr[9:2]] <= mif.mem_wdata;
      pipe[0] <= mem[mif.mem_addr[9:2]];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    always @(negedge clk) begin
      if (mif.busy) n_busy <= n_busy + 1;
      if (mif.done) begin
        n_done   <= n_done + 1;
        done_cyc <= cyc;
        mis_s    <= mif.misaligned;
        maddr_s  <= mif.mem_addr;
      end
      if (mif.mem_wr) begin
        n_wr    <= n_wr + 1;
        wr_cyc  <= cyc;
        wdata_s <= mif.mem_wdata;
        waddr_s <= mif.mem_addr;
      end
    end
  end

  // ---------------- reference model (from the access rules) ----------------
  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic exp_mis(input logic [1:0] isz, input logic [31:0] ia);
    if (isz == 2'b10) return 1'b0;
    if (isz == 2'b01) return ia[0];
    return ia[1:0] != 2'b00;
  endfunction

  function automatic int exp_k(input int lat, input logic iwe, input logic [1:0] isz,
                               input logic [31:0] ia);
    if (exp_mis(isz, ia)) return 1;
    if (!iwe) return lat + 2;
    if (isz == 2'b00 || isz == 2'b11) return 2;
    return lat + 3;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] isz,
                                           input logic isx, input logic [31:0] ia);
    int sh;
    logic [31:0] v;
    if (isz == 2'b10) begin
      sh = 8 * int'(ia[1:0]);
      v = (w >> sh) & 32'h0000_00FF;
      if (isx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (isz == 2'b01) begin
      sh = 16 * int'(ia[1]);
      v = (w >> sh) & 32'h0000_FFFF;
      if (isx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_merge(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [1:0] isz, input logic [31:0] ia);
    int sh;
    logic [31:0] mask;
    if (isz == 2'b10) begin
      sh = 8 * int'(ia[1:0]);
      mask = 32'h0000_00FF;
    end else if (isz == 2'b01) begin
      sh = 16 * int'(ia[1]);
      mask = 32'h0000_FFFF;
    end else begin
      return wd;
    end
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  task automatic model_commit(input logic iwe, input logic [1:0] isz, input logic isx,
                              input logic [31:0] ia, input logic [31:0] iwd);
    if (exp_mis(isz, ia)) return;
    ref_maddr = {ia[31:2], 2'b00};
    if (iwe) ref_mem[ia[9:2]] = exp_merge(ref_mem[ia[9:2]], iwd, isz, ia);
    else     ref_rd = exp_load(ref_mem[ia[9:2]], isz, isx, ia);
  endtask

  // ---------------- stimulus ----------------
  int          o_k[2], o_nd[2], o_nw[2], o_wk[2], o_nb[2];
  logic        o_mis[2];
  logic [31:0] o_maddr[2], o_wdata[2], o_waddr[2], o_rd[2];

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one request, optionally raises a stray start in cycle 'extra',
  // runs a fixed 14-cycle window and collects what each instance did.
  task automatic issue(input logic iwe, input logic [1:0] isz, input logic isx,
                       input logic [31:0] ia, input logic [31:0] iwd, input int extra);
    int s;
    int nd0[2], nw0[2], nb0[2];
    @(negedge clk); #1;
    nd0[0] = g_dut[0].n_done; nw0[0] = g_dut[0].n_wr; nb0[0] = g_dut[0].n_busy;
    nd0[1] = g_dut[1].n_done; nw0[1] = g_dut[1].n_wr; nb0[1] = g_dut[1].n_busy;
    start = 1'b1; we = iwe; size = isz; sign_ext = isx; addr = ia; wr_data = iwd;
    @(posedge clk); #1;
    s = cyc;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == extra) begin
        start = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h0; wr_data = 32'hFFFF_FFFF;
      end else if (k == extra + 1) begin
        start = 1'b0;
      end
    end
    #1;
    o_k[0] = g_dut[0].done_cyc - s + 1;   o_k[1] = g_dut[1].done_cyc - s + 1;
    o_wk[0] = g_dut[0].wr_cyc - s + 1;    o_wk[1] = g_dut[1].wr_cyc - s + 1;
    o_nd[0] = g_dut[0].n_done - nd0[0];   o_nd[1] = g_dut[1].n_done - nd0[1];
    o_nw[0] = g_dut[0].n_wr - nw0[0];     o_nw[1] = g_dut[1].n_wr - nw0[1];
    o_nb[0] = g_dut[0].n_busy - nb0[0];   o_nb[1] = g_dut[1].n_busy - nb0[1];
    o_mis[0] = g_dut[0].mis_s;            o_mis[1] = g_dut[1].mis_s;
    o_maddr[0] = g_dut[0].maddr_s;        o_maddr[1] = g_dut[1].maddr_s;
    o_wdata[0] = g_dut[0].wdata_s;        o_wdata[1] = g_dut[1].wdata_s;
    o_waddr[0] = g_dut[0].waddr_s;        o_waddr[1] = g_dut[1].waddr_s;
    o_rd[0] = g_dut[0].mif.rd_data;       o_rd[1] = g_dut[1].mif.rd_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (g_dut[0].outs_vec !== 100'b0) begin
      fails++; $display("FAIL reset_outputs lat1: got %h expected 0", g_dut[0].outs_vec);
    end
    tests++;
    if (g_dut[1].outs_vec !== 100'b0) begin
      fails++; $display("FAIL reset_outputs lat3: got %h expected 0", g_dut[1].outs_vec);
    end
    @(negedge clk);
    reset = 1'b0;
    ref_rd = '0; ref_maddr = '0;
  endtask

  task automatic test_word_load();
    preload(8'h41, 32'hDEAD_BEEF);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0, 0);
    model_commit(1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (o_k[i] !== lat_of(i) + 2 || o_nd[i] !== 1) begin
        fails++; $display("FAIL word_load_done dut%0d: got cycle %0d x%0d expected cycle %0d x1", i, o_k[i], o_nd[i], lat_of(i) + 2);
      end
      tests++;
      if (o_rd[i] !== 32'hDEAD_BEEF || o_maddr[i] !== 32'h0000_0104) begin
        fails++; $display("FAIL word_load_data dut%0d: got rd %h addr %h expected rd deadbeef addr 00000104", i, o_rd[i], o_maddr[i]);
      end
    end
  endtask

  task automatic test_subword_loads();
    logic [31:0] exp_v [3];
    logic [31:0] ia [3];
    logic [1:0]  sz [3];
    logic        sx [3];
    exp_v[0] = 32'hFFFF_FF80; ia[0] = 32'h17; sz[0] = 2'b10; sx[0] = 1'b1;
    exp_v[1] = 32'h0000_0080; ia[1] = 32'h17; sz[1] = 2'b10; sx[1] = 1'b0;
    exp_v[2] = 32'hFFFF_8070; ia[2] = 32'h16; sz[2] = 2'b01; sx[2] = 1'b1;
    preload(8'h05, 32'h8070_6050);
    for (int t = 0; t < 3; t++) begin
      issue(1'b0, sz[t], sx[t], ia[t], 32'h0, 0);
      model_commit(1'b0, sz[t], sx[t], ia[t], 32'h0);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (o_rd[i] !== exp_v[t] || o_k[i] !== lat_of(i) + 2) begin
          fails++; $display("FAIL subword_load%0d dut%0d: got %h at cycle %0d expected %h at cycle %0d", t, i, o_rd[i], o_k[i], exp_v[t], lat_of(i) + 2);
        end
      end
    end
  endtask

  task automatic test_byte_store();
    preload(8'h80, 32'h1122_3344);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0201, 32'h0000_00AB, 0);
    model_commit(1'b1, 2'b10, 1'b0, 32'h0000_0201, 32'h0000_00AB);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (o_nw[i] !== 1 || o_wdata[i] !== 32'h1122_AB44 || o_waddr[i] !== 32'h0000_0200) begin
        fails++; $display("FAIL byte_store_write dut%0d: got %0d writes data %h addr %h expected 1 write 1122ab44 at 00000200", i, o_nw[i], o_wdata[i], o_waddr[i]);
      end
      tests++;
      if (o_k[i] !== lat_of(i) + 3 || o_wk[i] !== lat_of(i) + 2) begin
        fails++; $display("FAIL byte_store_timing dut%0d: got wr %0d done %0d expected wr %0d done %0d", i, o_wk[i], o_k[i], lat_of(i) + 2, lat_of(i) + 3);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd_before;
    rd_before = ref_rd;
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0, 0);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (o_k[i] !== 1 || o_mis[i] !== 1'b1 || o_nw[i] !== 0 || o_rd[i] !== rd_before) begin
        fails++; $display("FAIL misaligned_word_load dut%0d: got cycle %0d mis %b writes %0d rd %h expected 1 1 0 %h", i, o_k[i], o_mis[i], o_nw[i], o_rd[i], rd_before);
      end
    end
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_5A5A, 0);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (o_k[i] !== 1 || o_mis[i] !== 1'b1 || o_nw[i] !== 0 || o_rd[i] !== rd_before) begin
        fails++; $display("FAIL misaligned_half_store dut%0d: got cycle %0d mis %b writes %0d rd %h expected 1 1 0 %h", i, o_k[i], o_mis[i], o_nw[i], o_rd[i], rd_before);
      end
    end
  endtask

  task automatic test_ignore_start();
    for (int e = 2; e <= 3; e++) begin
      issue(1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0, e);
      model_commit(1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (o_nd[i] !== 1 || o_nw[i] !== 0 || o_k[i] !== lat_of(i) + 2 || o_rd[i] !== 32'hDEAD_BEEF) begin
          fails++; $display("FAIL ignore_start_c%0d dut%0d: got %0d dones %0d writes cycle %0d rd %h expected 1 0 %0d deadbeef", e, i, o_nd[i], o_nw[i], o_k[i], o_rd[i], lat_of(i) + 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nd0[2], nw0[2];
    preload(8'h04, 32'hCAFE_F00D);
    @(negedge clk); #1;
    nd0[0] = g_dut[0].n_done; nw0[0] = g_dut[0].n_wr;
    nd0[1] = g_dut[1].n_done; nw0[1] = g_dut[1].n_wr;
    start = 1'b1; we = 1'b1; size = 2'b01; sign_ext = 1'b0; addr = 32'h12; wr_data = 32'h0000_1234;
    @(negedge clk); start = 1'b0;      // cycle 1 (REQ)
    @(negedge clk); #2; reset = 1'b1;  // cycle 2 (WAIT), between edges
    #1;
    tests++;
    if (g_dut[0].outs_vec !== 100'b0) begin
      fails++; $display("FAIL reset_mid_outputs lat1: got %h expected 0", g_dut[0].outs_vec);
    end
    tests++;
    if (g_dut[1].outs_vec !== 100'b0) begin
      fails++; $display("FAIL reset_mid_outputs lat3: got %h expected 0", g_dut[1].outs_vec);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ref_rd = '0; ref_maddr = '0;
    repeat (10) @(negedge clk);
    #1;
    tests++;
    if (g_dut[0].n_done != nd0[0] || g_dut[0].n_wr != nw0[0] || g_dut[1].n_done != nd0[1] || g_dut[1].n_wr != nw0[1]) begin
      fails++; $display("FAIL reset_mid_quiet: got dones %0d/%0d writes %0d/%0d expected 0", g_dut[0].n_done - nd0[0], g_dut[1].n_done - nd0[1], g_dut[0].n_wr - nw0[0], g_dut[1].n_wr - nw0[1]);
    end
    // the dropped store must leave the word untouched
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0, 0);
    model_commit(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (o_nd[i] !== 1 || o_k[i] !== lat_of(i) + 2 || o_rd[i] !== 32'hCAFE_F00D) begin
        fails++; $display("FAIL load_after_reset dut%0d: got %0d dones cycle %0d rd %h expected 1 %0d cafef00d", i, o_nd[i], o_k[i], o_rd[i], lat_of(i) + 2);
      end
    end
  endtask

  task automatic test_random();
    logic        rwe, rsx, emis;
    logic [1:0]  rsz;
    logic [31:0] ra, rwd, e_rd, e_wd, e_ma;
    int          ek;
    for (int i = 0; i < 16; i++) preload(8'(i), $urandom);
    for (int t = 0; t < 40; t++) begin
      rwe = 1'($urandom_range(0, 1));
      rsx = 1'($urandom_range(0, 1));
      rsz = 2'($urandom_range(0, 3));
      ra  = 32'($urandom_range(0, 63));
      rwd = $urandom;
      emis = exp_mis(rsz, ra);
      e_wd = exp_merge(ref_mem[ra[9:2]], rwd, rsz, ra);
      issue(rwe, rsz, rsx, ra, rwd, 0);
      model_commit(rwe, rsz, rsx, ra, rwd);
      e_rd = ref_rd;
      e_ma = ref_maddr;
      for (int i = 0; i < 2; i++) begin
        ek = exp_k(lat_of(i), rwe, rsz, ra);
        tests++;
        if (o_k[i] !== ek || o_nd[i] !== 1 || o_nb[i] !== ek || o_mis[i] !== emis) begin
          fails++; $display("FAIL rand%0d_ctl dut%0d: got done %0d x%0d busy %0d mis %b expected %0d x1 busy %0d mis %b", t, i, o_k[i], o_nd[i], o_nb[i], o_mis[i], ek, ek, emis);
        end
        tests++;
        if (o_rd[i] !== e_rd || o_maddr[i] !== e_ma) begin
          fails++; $display("FAIL rand%0d_data dut%0d: got rd %h addr %h expected rd %h addr %h", t, i, o_rd[i], o_maddr[i], e_rd, e_ma);
        end
        tests++;
        if (rwe && !emis) begin
          if (o_nw[i] !== 1 || o_wdata[i] !== e_wd || o_wk[i] !== ek - 1 || o_waddr[i] !== e_ma) begin
            fails++; $display("FAIL rand%0d_store dut%0d: got %0d writes %h at %h cycle %0d expected 1 %h at %h cycle %0d", t, i, o_nw[i], o_wdata[i], o_waddr[i], o_wk[i], e_wd, e_ma, ek - 1);
          end
        end else if (o_nw[i] !== 0) begin
          fails++; $display("FAIL rand%0d_nowrite dut%0d: got %0d writes expected 0", t, i, o_nw[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_loads();
    test_byte_store();
    test_misaligned();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequential memory-access controller directly downstream of the IorD address multiplexer.
- Takes the selected 32-bit byte address plus the access kind from the control unit. Drives the synchronous single-port 32-bit data memory.
- Provides byte/halfword/word loads with sign or zero extension, and byte/halfword stores by read-modify-write.
- Flags misaligned accesses to the exception logic without touching memory.

Parameters:
MEM_LAT, 1, memory read latency in cycles from address-valid to data-valid; legal range 1..4

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE
we  input  1  0 = load, 1 = store
size  input  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word)
sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  input  32  byte address from the IorD multiplexer
wr_data  input  32  store data, right-justified (byte in [7:0], half in [15:0])
mem_addr  output  32  word-aligned address to memory (addr with [1:0] = 00)
mem_wr  output  1  memory write enable
mem_wdata  output  32  write data to memory
mem_rdata  input  32  read data from memory
rd_data  output  32  extended load result; valid when done=1, held until next done
busy  output  1  high from the cycle after start acceptance until the cycle done is high
done  output  1  one-cycle completion pulse
misaligned  output  1  one-cycle pulse coincident with done for a rejected access

Behaviour:
- Reset: clk is the only clock; reset is asynchronous and active-high. While reset is high, the state is IDLE and all outputs are 0, including mem_wr. A reset mid-operation aborts it immediately: no done pulse, and a pending write is dropped.
- Byte lanes are little-endian: byte offset 0 maps to bits [7:0] and offset 3 to [31:24]. Halfword offset 0 maps to [15:0] and offset 2 to [31:16].
- Misalignment: size=01 with addr[0]=1, or size=00/11 with addr[1:0]≠00.
- States: IDLE, REQ, WAIT, RMW_WR, DONE.
  - IDLE: when start=1, latch addr, we, size, sign_ext and wr_data.
    - Misaligned: go to DONE with misaligned=1.
    - Word store: go to RMW_WR directly.
    - Otherwise: go to REQ.
  - REQ: drive mem_addr and mem_wr=0. Load a wait counter with MEM_LAT-1, then go to WAIT.
  - WAIT: decrement the counter. At zero, sample mem_rdata into a data register.
    - Load: extract the lane, extend it into rd_data, go to DONE.
    - Sub-word store: go to RMW_WR.
  - RMW_WR: mem_wr=1 for exactly one cycle. mem_wdata is the merge of the sampled word with the new lane (sub-word store) or wr_data (word store). Go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Timing, with cycle 1 being the cycle after the start-sampling edge:
  - Load: done in cycle MEM_LAT+2.
  - Word store: mem_wr in cycle 1, done in cycle 2.
  - Sub-word store: mem_wr in cycle MEM_LAT+2, done in cycle MEM_LAT+3.
  - Misaligned: done and misaligned in cycle 1; mem_wr never asserted.
- mem_addr is held stable from REQ (or RMW_WR for word stores) through DONE. It is 0 in IDLE after reset, and otherwise holds its last value.
- start while busy or in DONE is ignored; the request is not queued. A new start is accepted in the IDLE cycle following DONE.
- rd_data is unchanged by stores and by misaligned accesses.

Decomposition:
- Shared package holds:
  - size encodings: SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - state encodings;
  - MEM_LAT limits.
- One natural sub-module, lane_unit: purely combinational. It performs load lane extraction with sign/zero extension and store lane merge. It is shared by the read and RMW paths.

Test Plan:
- Word load, MEM_LAT=1, addr=0x0000_0104, memory word=0xDEAD_BEEF -> mem_addr=0x104, done in cycle 3, rd_data=0xDEAD_BEEF.
- Byte loads from word 0x8070_6050, addr offset 3 -> sign_ext=1 gives rd_data=0xFFFF_FF80, sign_ext=0 gives 0x0000_0080. Half at offset 2, sign_ext=1 -> 0xFFFF_8070.
- Byte store wr_data=0xAB to addr=0x0000_0201, memory word 0x1122_3344 -> exactly one mem_wr pulse with mem_wdata=0x1122_AB44 at mem_addr=0x200, done in cycle 4 (MEM_LAT=1).
- Misaligned: word load addr=0x0000_0102 -> done=misaligned=1 in cycle 1, mem_wr never high, rd_data unchanged. Half store addr=0x0000_0003 gives the same response.
- MEM_LAT=3 word load -> done in cycle 5. A start pulse in cycle 2 is ignored, giving exactly one done.
- Reset asserted during the WAIT of a half store -> outputs 0 asynchronously, no mem_wr or done afterwards. A new load after reset completes normally.
